// File: rtl/controller.sv
// ----------------------------------------------------------------------------
// controller -- eight-phase VeriRISC sequencer
//
// Steps through eight phases per instruction and decodes the registered phase,
// the IR opcode and the accumulator zero flag into the datapath strobes.
//
// Parameters:
//   HALT_STICKY  1: HLT freezes the sequencer (phase held at OP_FETCH) until rst
//                0: halt is a one-cycle pulse in OP_ADDR, sequencing continues
//
// Optional feature macro:
//   CTRL_STEP_EN  adds input 'step'; in INST_ADDR the phase advances only when
//                 step is high on the edge (single-instruction stepping)
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   step    in   (CTRL_STEP_EN only) advance out of INST_ADDR
//   opcode  in   [2:0] IR opcode
//   zero    in   accumulator == 0
//   sel     out  address mux select (1 = PC, 0 = IR address)
//   rd, wr  out  memory read / write
//   ld_ir, ld_ac, ld_pc, inc_pc  out  register load / PC increment strobes
//   halt    out  halted / halting
//   data_e  out  accumulator drives data bus
//   phase   out  [2:0] current phase
// ----------------------------------------------------------------------------
module controller #(
    parameter int unsigned HALT_STICKY = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef CTRL_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       halt,
    output logic       data_e,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    phase_t  phase_q, phase_d;
    logic    halted_q, halted_d;
    logic    advance;
    logic    aluop;
    opcode_t op;

    assign op    = opcode_t'(opcode);
    assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        advance  = 1'b1;
`ifdef CTRL_STEP_EN
        if (phase_q == INST_ADDR && !step)
            advance = 1'b0;
`endif
        if (!halted_q) begin
            // Sticky halt still moves OP_ADDR -> OP_FETCH on the halting edge,
            // then the halted flag freezes the phase there.
            if (HALT_STICKY != 0 && phase_q == OP_ADDR && op == OP_HLT) begin
                halted_d = 1'b1;
                phase_d  = OP_FETCH;
            end else if (advance) begin
                phase_d = phase_t'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        phase  = phase_q;
        if (rst) begin
            sel   = 1'b1;
            phase = '0;
        end else if (halted_q) begin
            sel  = 1'b1;
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
                INST_LOAD:  begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == OP_HLT);
                end
                OP_FETCH:   rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == OP_SKZ) && zero;
                    ld_pc  = (op == OP_JMP);
                    data_e = (op == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    wr     = (op == OP_STO);
                    ld_pc  = (op == OP_JMP);
                    data_e = (op == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// ----------------------------------------------------------------------------
// tb_controller -- self-checking bench for controller.
// Two instances share the inputs: one with sticky halt, one with pulsed halt.
// Each cycle the outputs are compared against a reference model built from the
// phase-by-phase strobe rules and a simple phase/halted state tracker.
// ----------------------------------------------------------------------------
module tb_controller;

`ifdef CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       step = 1'b1;

    logic       s_sel, s_rd, s_wr, s_ld_ir, s_ld_ac, s_ld_pc, s_inc_pc, s_halt, s_data_e;
    logic [2:0] s_phase;
    logic       p_sel, p_rd, p_wr, p_ld_ir, p_ld_ac, p_ld_pc, p_inc_pc, p_halt, p_data_e;
    logic [2:0] p_phase;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // model state
    int ms_ph = 0;  // sticky instance phase
    bit ms_h  = 0;  // sticky instance halted
    int mp_ph = 0;  // pulse instance phase

    always #5 clk = ~clk;

    controller #(.HALT_STICKY(1)) dut_s (
        .clk(clk), .rst(rst),
`ifdef CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .sel(s_sel), .rd(s_rd), .wr(s_wr), .ld_ir(s_ld_ir), .ld_ac(s_ld_ac),
        .ld_pc(s_ld_pc), .inc_pc(s_inc_pc), .halt(s_halt), .data_e(s_data_e),
        .phase(s_phase)
    );

    controller #(.HALT_STICKY(0)) dut_p (
        .clk(clk), .rst(rst),
`ifdef CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .sel(p_sel), .rd(p_rd), .wr(p_wr), .ld_ir(p_ld_ir), .ld_ac(p_ld_ac),
        .ld_pc(p_ld_pc), .inc_pc(p_inc_pc), .halt(p_halt), .data_e(p_data_e),
        .phase(p_phase)
    );

    // {phase[2:0], sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e}
    function automatic logic [11:0] expect_out(input int ph, input bit h,
                                               input bit r, input int op, input bit z);
        bit aluop;
        bit e_sel, e_rd, e_wr, e_ld_ir, e_ld_ac, e_ld_pc, e_inc_pc, e_halt, e_data_e;
        aluop = (op >= 2 && op <= 5);
        if (r) return {3'd0, 9'b1_0000_0000};
        if (h) return {ph[2:0], 9'b1_0000_0010};
        e_sel    = (ph < 4);
        e_rd     = (ph >= 1 && ph <= 3) || (aluop && ph >= 5);
        e_wr     = (op == 6) && (ph == 7);
        e_ld_ir  = (ph == 2) || (ph == 3);
        e_ld_ac  = aluop && (ph == 7);
        e_ld_pc  = (op == 7) && (ph >= 6);
        e_inc_pc = (ph == 4) || ((ph == 6) && (op == 1) && z);
        e_halt   = (ph == 4) && (op == 0);
        e_data_e = (op == 6) && (ph >= 6);
        return {ph[2:0], e_sel, e_rd, e_wr, e_ld_ir, e_ld_ac, e_ld_pc, e_inc_pc, e_halt, e_data_e};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs, then advance the model on the edge.
    task automatic cycle(input bit r, input logic [2:0] op, input bit z, input bit st);
        @(negedge clk);
        rst = r; opcode = op; zero = z; step = st;
        #1;
        check("sticky", {s_phase, s_sel, s_rd, s_wr, s_ld_ir, s_ld_ac, s_ld_pc, s_inc_pc, s_halt, s_data_e},
              expect_out(ms_ph, ms_h, r, int'(op), z));
        check("pulse", {p_phase, p_sel, p_rd, p_wr, p_ld_ir, p_ld_ac, p_ld_pc, p_inc_pc, p_halt, p_data_e},
              expect_out(mp_ph, 1'b0, r, int'(op), z));
        @(posedge clk);
        if (r) begin
            ms_ph = 0; ms_h = 0; mp_ph = 0;
        end else begin
            if (!ms_h) begin
                if (ms_ph == 4 && op == 3'd0) begin
                    ms_h = 1; ms_ph = 5;
                end else if (!(STEP_EN && ms_ph == 0 && !st)) begin
                    ms_ph = (ms_ph + 1) % 8;
                end
            end
            if (!(STEP_EN && mp_ph == 0 && !st))
                mp_ph = (mp_ph + 1) % 8;
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input bit z);
        for (int i = 0; i < 8; i++) cycle(1'b0, op, z, 1'b1);
    endtask

    logic [2:0] cur_op;
    bit         cur_z;

    initial begin
        // reset held two clocks, then free-running sequence
        cycle(1'b1, 3'd5, 1'b0, 1'b1);
        cycle(1'b1, 3'd5, 1'b0, 1'b1);
        run_instr(3'd5, 1'b0);   // LDA
        run_instr(3'd6, 1'b0);   // STO
        run_instr(3'd1, 1'b1);   // SKZ, zero set
        run_instr(3'd1, 1'b0);   // SKZ, zero clear
        run_instr(3'd7, 1'b0);   // JMP
        run_instr(3'd2, 1'b1);   // ADD
        run_instr(3'd0, 1'b0);   // HLT
        for (int i = 0; i < 20; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 1'b0, 1'b1);
        // reset mid-instruction at phase 6 with JMP
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 3'd7, 1'b0, 1'b1);
        cycle(1'b0, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 3'd7, 1'b0, 1'b1);
        if (STEP_EN) begin
            for (int i = 0; i < 5; i++) cycle(1'b0, 3'd5, 1'b0, 1'b0);
            cycle(1'b0, 3'd5, 1'b0, 1'b1);
            for (int i = 0; i < 12; i++) cycle(1'b0, 3'd5, 1'b0, 1'b0);
        end

        // randomized operation
        cur_op = 3'd5;
        cur_z  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (mp_ph == 0) begin
                cur_op = 3'($urandom_range(0, 7));
                cur_z  = 1'($urandom_range(0, 1));
            end
            cycle(($urandom_range(0, 49) == 0), cur_op, cur_z, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
